// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// inst_fetch_unit : decoupled RV32I fetch front end with a PC-tagged FIFO
// Revision        : 1.0
// ============================================================================
module inst_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [DATA_WIDTH-1:0]   imem_req_addr,
  input  logic                    imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_resp_data,
  input  logic                    redirect,
  input  logic [DATA_WIDTH-1:0]   redirect_pc,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [DATA_WIDTH-1:0]   inst_data,
  output logic [DATA_WIDTH-1:0]   inst_pc,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  // Redirects can stack dropped responses on top of live ones, so headroom is kept.
  localparam int c_OW = c_AW + 4;

  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_resp_pc;
  logic [c_OW-1:0]       r_outstanding;
  logic [c_OW-1:0]       r_drop_cnt;
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_pc   [DEPTH];
  logic [c_AW-1:0]       r_rd_ptr;
  logic [c_AW-1:0]       r_wr_ptr;
  logic [c_CW-1:0]       r_count;

  logic [c_OW-1:0]       w_live;
  logic [c_OW-1:0]       w_credit;
  logic [c_OW-1:0]       w_out_next;
  logic [c_CW-1:0]       w_count_next;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_dropping;
  logic [DATA_WIDTH-1:0] w_redirect_pc;

  assign w_live         = r_outstanding - r_drop_cnt;
  assign w_credit       = c_OW'(r_count) + w_live;
  assign imem_req_valid = !rst && !redirect && (w_credit < c_OW'(DEPTH));
  assign imem_req_addr  = rst ? '0 : r_fetch_pc;
  assign inst_valid     = !rst && (r_count != '0) && !redirect;
  assign inst_data      = rst ? '0 : r_mem_data[r_rd_ptr];
  assign inst_pc        = rst ? '0 : r_mem_pc[r_rd_ptr];
  assign fifo_count     = r_count;

  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_pop          = inst_valid && inst_ready;
  assign w_dropping     = (r_drop_cnt != '0);
  assign w_push         = imem_resp_valid && !w_dropping && !redirect;
  assign w_redirect_pc  = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

  always_comb begin
    w_out_next = r_outstanding;
    if (w_accept && !imem_resp_valid)
      w_out_next = r_outstanding + c_OW'(1);
    else if (!w_accept && imem_resp_valid)
      w_out_next = r_outstanding - c_OW'(1);
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + c_CW'(1);
    else if (!w_push && w_pop)
      w_count_next = r_count - c_CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_accept)
        r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_drop_cnt <= w_out_next;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (imem_resp_valid && w_dropping)
          r_drop_cnt <= r_drop_cnt - c_OW'(1);
        if (w_push) begin
          r_wr_ptr  <= r_wr_ptr + c_AW'(1);
          r_resp_pc <= r_resp_pc + DATA_WIDTH'(4);
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + c_AW'(1);
        r_count <= w_count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem_data[r_wr_ptr] <= imem_resp_data;
      r_mem_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && !w_pop && (r_count == c_CW'(DEPTH))));
      assert (!(imem_resp_valid && (r_outstanding == '0)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch_unit : directed bench with a queue-level model of the fetch unit
// Revision           : 1.0
// ============================================================================
module tb_inst_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  inst_fetch_unit #(.DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fifo_count(fifo_count)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // In-order instruction memory with fixed latency, cleared by rst.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
      end else begin
        if (imem_resp_valid && mq.size() != 0) mq.delete(0);
        if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
      end
      @(posedge clk);
      #1;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
  end

  // Model: FIFO of delivered PCs plus in-flight request tags marked stale on redirect.
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  logic [31:0] m_fifo[$];
  fl_t         m_fl[$];
  logic [31:0] m_fetch_pc;
  bit          m_ok = 1'b0;

  initial begin
    int  live;
    bit  ev_req;
    bit  ev_inst;
    fl_t h;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_valid",  {31'b0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid},     32'd0);
        chk("rst_req_addr",   imem_req_addr,           32'd0);
        chk("rst_inst_pc",    inst_pc,                 32'd0);
        chk("rst_inst_data",  inst_data,               32'd0);
        m_fifo.delete();
        m_fl.delete();
        m_fetch_pc = 32'h0;
        m_ok = 1'b1;
      end else if (m_ok) begin
        live = 0;
        foreach (m_fl[i]) if (!m_fl[i].stale) live++;
        ev_req  = !redirect && (m_fifo.size() + live < DEPTH);
        ev_inst = (m_fifo.size() != 0) && !redirect;
        chk("req_valid",  {31'b0, imem_req_valid}, {31'b0, ev_req});
        chk("inst_valid", {31'b0, inst_valid},     {31'b0, ev_inst});
        chk("fifo_count", {29'b0, fifo_count},     m_fifo.size());
        if (ev_req) chk("req_addr", imem_req_addr, m_fetch_pc);
        if (m_fifo.size() != 0) begin
          chk("inst_pc",   inst_pc,   m_fifo[0]);
          chk("inst_data", inst_data, mem_word(m_fifo[0]));
        end
        if (ev_inst && inst_ready) m_fifo.delete(0);
        if (imem_resp_valid && m_fl.size() != 0) begin
          h = m_fl[0];
          m_fl.delete(0);
          if (!h.stale && !redirect) m_fifo.push_back(h.pc);
        end
        if (ev_req && imem_req_ready) begin
          m_fl.push_back('{m_fetch_pc, 1'b0});
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redirect) begin
          m_fifo.delete();
          foreach (m_fl[i]) m_fl[i].stale = 1'b1;
          m_fetch_pc = {redirect_pc[31:2], 2'b00};
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    tick(3);

    // Steady stream
    rst = 1'b0;
    #1;
    chk("s1_first_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("s1_first_addr",  imem_req_addr, 32'h0);
    tick(1); #1;
    chk("s1_no_inst_yet", {31'b0, inst_valid}, 32'd0);
    tick(1); #1;
    chk("s1_inst_valid",  {31'b0, inst_valid}, 32'd1);
    chk("s1_inst_pc",     inst_pc,   32'h0);
    chk("s1_inst_data",   inst_data, 32'hBEEF_FFFF);
    tick(10);

    // Decode stalled: credits cap requests at DEPTH
    inst_ready = 1'b0;
    do_reset();
    tick(8); #1;
    chk("s2_count_full", {29'b0, fifo_count}, 32'd4);
    chk("s2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    chk("s2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    #1;
    chk("s2_one_credit", {31'b0, imem_req_valid}, 32'd1);
    chk("s2_next_addr",  imem_req_addr, 32'h10);
    tick(6); #1;
    chk("s2_refull",  {29'b0, fifo_count}, 32'd4);
    chk("s2_head_pc2", inst_pc, 32'h4);

    // Redirect with three requests in flight, L=3
    inst_ready = 1'b1; lat = 3;
    do_reset();
    tick(3);
    redirect = 1'b1; redirect_pc = 32'h42;
    #1;
    chk("s3_no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
    tick(1);
    redirect = 1'b0;
    #1;
    chk("s3_flushed",  {29'b0, fifo_count}, 32'd0);
    chk("s3_new_addr", imem_req_addr, 32'h40);
    tick(3); #1;
    chk("s3_stale_dropped", {31'b0, inst_valid}, 32'd0);
    tick(1); #1;
    chk("s3_first_valid", {31'b0, inst_valid}, 32'd1);
    chk("s3_first_pc",    inst_pc,   32'h40);
    chk("s3_first_data",  inst_data, 32'hBEAF_FFBF);

    // Redirect coinciding with a response and an attempted pop
    lat = 1;
    do_reset();
    tick(3);
    redirect = 1'b1; redirect_pc = 32'h101;
    #1;
    chk("s4_inst_valid_off", {31'b0, inst_valid}, 32'd0);
    chk("s4_req_off",        {31'b0, imem_req_valid}, 32'd0);
    chk("s4_count_before",   {29'b0, fifo_count}, 32'd1);
    tick(1);
    redirect = 1'b0;
    #1;
    chk("s4_count_after", {29'b0, fifo_count}, 32'd0);
    chk("s4_new_addr",    imem_req_addr, 32'h100);
    tick(2); #1;
    chk("s4_first_pc",   inst_pc,   32'h100);
    chk("s4_first_data", inst_data, 32'hBFEF_FEFF);

    // Memory not ready: request held stable
    imem_req_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s5_hold_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("s5_hold_addr",  imem_req_addr, 32'h0);
      tick(1);
    end
    imem_req_ready = 1'b1;
    tick(1); #1;
    chk("s5_advance", imem_req_addr, 32'h4);

    // Reset mid-stream with 2 buffered and 1 outstanding
    inst_ready = 1'b0;
    do_reset();
    tick(3);
    imem_req_ready = 1'b0;
    #1;
    chk("s6_count_pre", {29'b0, fifo_count}, 32'd2);
    rst = 1'b1;
    tick(1); #1;
    chk("s6_count_rst", {29'b0, fifo_count}, 32'd0);
    chk("s6_inst_rst",  {31'b0, inst_valid}, 32'd0);
    chk("s6_req_rst",   {31'b0, imem_req_valid}, 32'd0);
    tick(1);
    rst = 1'b0; imem_req_ready = 1'b1;
    #1;
    chk("s6_restart_addr", imem_req_addr, 32'h0);
    tick(2); #1;
    chk("s6_restart_pc", inst_pc, 32'h0);

    inst_ready = 1'b1;
    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Decoupled instruction-fetch front end for the RV32I core. It replaces the direct combinational instruction-memory read.
- Issues word-aligned fetch requests to a variable-latency instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- Handles control-flow redirects (taken branch/jump) by flushing the buffer and discarding stale in-flight responses.

Parameters:
- DATA_WIDTH, 32, width of addresses, PCs and instruction words
- DEPTH, 4, FIFO entries and maximum live requests; must be a power of 2 and at least 2
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_req_addr  out  DATA_WIDTH  fetch address (word aligned)
- imem_resp_valid  in  1  response data valid; in order, at least 1 cycle after acceptance, never back-pressured
- imem_resp_data  in  DATA_WIDTH  instruction word
- redirect  in  1  single-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  DATA_WIDTH  new PC; bits [1:0] ignored and treated as 0
- inst_valid  out  1  decode-side instruction valid
- inst_ready  in  1  decode consumes the instruction
- inst_data  out  DATA_WIDTH  instruction at FIFO head
- inst_pc  out  DATA_WIDTH  PC of inst_data
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock domain, clk. rst is synchronous, active-high, and dominates every other input including redirect.
- Reset values:
  - fetch_pc = RESET_PC, resp_pc = RESET_PC
  - FIFO empty, fifo_count = 0
  - outstanding = 0, drop_cnt = 0
  - imem_req_valid = 0, inst_valid = 0
  - inst_data, inst_pc, imem_req_addr = 0 while rst is high
- The memory is reset by the same rst, so no response for a pre-reset request ever arrives.
- Live count: live = outstanding - drop_cnt.
- Issue rule:
  - imem_req_valid = !rst && !redirect && (fifo_count + live < DEPTH).
  - imem_req_addr = fetch_pc.
  - On acceptance (valid && ready): fetch_pc += 4, wrapping modulo 2^DATA_WIDTH, and outstanding += 1.
  - imem_req_addr is held stable while valid && !ready, except across a redirect.
- Response rule:
  - Every imem_resp_valid decrements outstanding.
  - If drop_cnt > 0, the response is discarded and drop_cnt -= 1.
  - Otherwise {imem_resp_data, resp_pc} is pushed into the FIFO and resp_pc += 4.
  - The credit rule guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure, as is a response while outstanding == 0.
- Simultaneous accept and response in one cycle: outstanding is unchanged.
- Decode side:
  - inst_valid = (fifo_count != 0) && !redirect.
  - inst_data and inst_pc come from the FIFO head; they are FIFO outputs, not registered separately.
  - A pop occurs on inst_valid && inst_ready.
  - Push and pop in the same cycle leave fifo_count unchanged. This is legal when full (pop frees the slot first in credit terms) and when empty is impossible (no bypass).
- Latency: request accepted at cycle t with response at t+L gives inst_valid at t+L+1.
- Redirect, at the next edge:
  - FIFO flushed.
  - fetch_pc and resp_pc set to {redirect_pc[DATA_WIDTH-1:2], 2'b00}.
  - drop_cnt = outstanding after this cycle's request/response accounting. No request is issued in the redirect cycle, and a response arriving in that same cycle is itself discarded.
  - Any pop attempted in the redirect cycle is ignored.
  - Fetch resumes the following cycle. New requests may issue while drop_cnt > 0; in-order return guarantees dropped responses arrive first.
- Back-to-back redirects: each one re-flushes, and drop_cnt is recomputed from outstanding.
- fifo_count reflects registered occupancy only.

Test Plan:
- Reset then steady stream (memory ready=1, L=1, inst_ready=1) -> requests at 0x0, 0x4, 0x8, ...; first inst_valid 2 cycles after the first accept with inst_pc=0x0; thereafter one instruction per cycle, with inst_pc incrementing by 4 and inst_data matching memory.
- inst_ready held 0 with DEPTH=4, L=1 -> exactly 4 requests accepted; fifo_count reaches 4; imem_req_valid stays 0. Raising inst_ready for one cycle pops the 0x0 entry and permits exactly one new request (0x10).
- L=3 with 3 requests in flight, then redirect with redirect_pc=0x42 -> FIFO empty next cycle; the 3 old responses are discarded; next request address is 0x40; first delivered inst_pc is 0x40.
- Redirect asserted in the same cycle as imem_resp_valid and inst_valid&&inst_ready -> that response is dropped, no pop is counted, imem_req_valid is 0 that cycle, and fifo_count is 0 next cycle.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 and imem_req_addr constant throughout; fetch_pc advances only after ready rises.
- rst asserted mid-stream with the FIFO holding 2 entries and 1 outstanding -> next cycle fifo_count=0, inst_valid=0, imem_req_valid=0; after rst falls, fetch restarts at RESET_PC.
